gf2_poly_reducer: RTL and testbench

//  Digit-serial GF(2)[x] modular reducer sitting directly downstream of the 32x41 carry-less

---
 rtl/gf2_reduce_pkg.sv | 23 ++
 rtl/gf2_reduce_digit.sv | 42 ++++
 rtl/gf2_poly_reducer.sv | 113 +++++++++++
 tb/tb_gf2_poly_reducer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_reduce_pkg.sv
// Shared definitions for the GF(2)[x] modular reducer.
//   - Default widths and reduction polynomial for the reducer that sits after the 32x41
//     carry-less multiplier.
//   - num_iter(): number of REDUCE cycles needed to clear every product bit at or above M.
//   - state_t: reducer controller states.
package gf2_reduce_pkg;

  localparam int              IN_W_DEF  = 73;
  localparam int              M_DEF     = 41;
  localparam logic [M_DEF-1:0] POLY_DEF = 41'h000_0000_0009;  // x^41 + x^3 + 1, x^41 implicit
  localparam int              DIGIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int num_iter(input int in_w, input int m, input int digit);
    return (in_w - m + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/gf2_reduce_digit.sv
// One digit of the reduction.
// Clears up to DIGIT bits of acc_in, walking from bit 'top' downwards. Each set bit k >= M is
// folded back using x^k = x^(k-M) * POLY (mod x^M + POLY). Bits below M are left alone.
// Ports:
//   acc_in   in   IN_W   partially reduced accumulator
//   top      in   TOP_W  highest bit index handled this cycle
//   acc_out  out  IN_W   accumulator after this digit
module gf2_reduce_digit
  import gf2_reduce_pkg::*;
#(
  parameter int             IN_W  = IN_W_DEF,
  parameter int             M     = M_DEF,
  parameter logic [M-1:0]   POLY  = POLY_DEF,
  parameter int             DIGIT = DIGIT_DEF,
  parameter int             TOP_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  acc_in,
  input  logic [TOP_W-1:0] top,
  output logic [IN_W-1:0]  acc_out
);

  localparam logic [IN_W-1:0] POLY_EXT = {{(IN_W-M){1'b0}}, POLY};
  localparam logic [IN_W-1:0] ONE      = IN_W'(1);

  logic [IN_W-1:0] acc_v;
  int              k;

  // Bits are processed MSB first so a fold landing inside the same digit is seen by the
  // following lower bits in the same cycle.
  always_comb begin
    acc_v = acc_in;
    k     = 0;
    for (int j = 0; j < DIGIT; j++) begin
      k = int'(top) - j;
      if (k >= M && ((acc_v & (ONE << k)) != '0)) begin
        acc_v = acc_v ^ (ONE << k) ^ (POLY_EXT << (k - M));
      end
    end
    acc_out = acc_v;
  end

endmodule

// File: rtl/gf2_poly_reducer.sv
// Digit-serial reducer: in_data mod (x^M + POLY) over GF(2), one operation in flight,
// fixed latency of NUM_ITER cycles from the accepting edge to out_valid.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous reset, active low
//   in_valid   in   1     in_data valid
//   in_ready   out  1     reducer idle and able to accept
//   in_data    in   IN_W  carry-less product
//   out_valid  out  1     out_data holds a result
//   out_ready  in   1     consumer takes out_data
//   out_data   out  M     reduced field element
//   busy       out  1     reducing or holding a result
//
// state     | meaning
// ST_IDLE   | waiting for a product, in_ready high
// ST_REDUCE | clearing DIGIT bits per cycle, NUM_ITER cycles
// ST_DONE   | result presented until out_valid && out_ready
module gf2_poly_reducer
  import gf2_reduce_pkg::*;
#(
  parameter int           IN_W  = IN_W_DEF,
  parameter int           M     = M_DEF,
  parameter logic [M-1:0] POLY  = POLY_DEF,
  parameter int           DIGIT = DIGIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    out_data,
  output logic            busy
);

  localparam int NUM_ITER = num_iter(IN_W, M, DIGIT);
  localparam int ITER_W   = $clog2(NUM_ITER + 1);
  localparam int TOP_W    = $clog2(IN_W);

  if (DIGIT < 1 || DIGIT > IN_W - M) begin : g_bad_digit
    $error("gf2_poly_reducer: DIGIT must be in 1..IN_W-M");
  end
  if (POLY[0] != 1'b1) begin : g_bad_poly
    $error("gf2_poly_reducer: POLY must have a constant term");
  end

  state_t            state_q, state_d;
  logic [IN_W-1:0]   acc_q, acc_d, acc_red;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [TOP_W-1:0]  top_idx;

  assign top_idx = TOP_W'(IN_W - 1 - int'(iter_q) * DIGIT);

  gf2_reduce_digit #(
    .IN_W  (IN_W),
    .M     (M),
    .POLY  (POLY),
    .DIGIT (DIGIT),
    .TOP_W (TOP_W)
  ) u_digit (
    .acc_in  (acc_q),
    .top     (top_idx),
    .acc_out (acc_red)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          iter_d  = '0;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        acc_d  = acc_red;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(NUM_ITER - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  // in_ready is gated by rst so it reads low for the whole reset interval.
  assign in_ready  = (state_q == ST_IDLE) && rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? acc_q[M-1:0] : '0;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gf2_poly_reducer.sv
module tb_gf2_poly_reducer;

  localparam int           IN_W     = 73;
  localparam int           M        = 41;
  localparam logic [M-1:0] POLY     = 41'h9;
  localparam int           NUM_ITER = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [IN_W-1:0] in_data = '0;

  logic            in_ready, out_valid, busy;
  logic [M-1:0]    out_data;
  logic            in_ready_d1, out_valid_d1, busy_d1;
  logic [M-1:0]    out_data_d1;
  logic            in_ready_d32, out_valid_d32, busy_d32;
  logic [M-1:0]    out_data_d32;

  int vecs = 0;
  int errs = 0;

  logic [M-1:0] pow_tab [IN_W];

  always #5 clk = ~clk;

  gf2_poly_reducer #(.IN_W(IN_W), .M(M), .POLY(POLY), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  gf2_poly_reducer #(.IN_W(IN_W), .M(M), .POLY(POLY), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d1), .in_data(in_data),
    .out_valid(out_valid_d1), .out_ready(out_ready), .out_data(out_data_d1), .busy(busy_d1)
  );

  gf2_poly_reducer #(.IN_W(IN_W), .M(M), .POLY(POLY), .DIGIT(32)) dut_d32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d32), .in_data(in_data),
    .out_valid(out_valid_d32), .out_ready(out_ready), .out_data(out_data_d32), .busy(busy_d32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x^k mod (x^M + POLY) built by repeated multiplication by x.
  task automatic build_pow_tab;
    logic [M-1:0] p;
    logic         msb;
    p = M'(1);
    for (int k = 0; k < IN_W; k++) begin
      pow_tab[k] = p;
      msb = p[M-1];
      p = {p[M-2:0], 1'b0} ^ (msb ? POLY : '0);
    end
  endtask

  function automatic logic [M-1:0] ref_mod(input logic [IN_W-1:0] d);
    logic [M-1:0] r;
    r = '0;
    for (int k = 0; k < IN_W; k++) if (d[k]) r = r ^ pow_tab[k];
    return r;
  endfunction

  function automatic logic [IN_W-1:0] clmul(input logic [31:0] a, input logic [M-1:0] b);
    logic [IN_W-1:0] prod;
    prod = '0;
    for (int i = 0; i < 32; i++) if (a[i]) prod = prod ^ ({{(IN_W-M){1'b0}}, b} << i);
    return prod;
  endfunction

  function automatic logic [IN_W-1:0] rand_wide();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[IN_W-1:0];
  endfunction

  task automatic accept(input string tag, input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check({tag, "_in_ready"}, IN_W'(in_ready), IN_W'(1));
    tick;
    in_valid = 1'b0;
    in_data  = rand_wide();
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick;
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [IN_W-1:0] d, input logic [M-1:0] exp);
    int lat;
    accept(tag, d);
    wait_result(lat);
    check({tag, "_lat"}, IN_W'(lat), IN_W'(NUM_ITER));
    check({tag, "_data"}, IN_W'(out_data), IN_W'(exp));
    check({tag, "_model"}, IN_W'(out_data), IN_W'(ref_mod(d)));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_drop"}, IN_W'(out_valid), IN_W'(0));
  endtask

  initial begin
    logic [IN_W-1:0] v, a_vec, b_vec;
    logic [M-1:0]    exp_a;
    logic [63:0]     r64;
    logic [31:0]     ra;
    logic [M-1:0]    rb;
    int              lat;
    int              n;

    build_pow_tab();

    // Reset state
    tick;
    check("rst_in_ready", IN_W'(in_ready), IN_W'(0));
    check("rst_out_valid", IN_W'(out_valid), IN_W'(0));
    check("rst_out_data", IN_W'(out_data), IN_W'(0));
    check("rst_busy", IN_W'(busy), IN_W'(0));
    rst = 1'b1;
    #1;
    check("rel_in_ready", IN_W'(in_ready), IN_W'(1));

    // Directed vectors
    v = '0; v[41] = 1'b1;
    directed("x41", v, 41'h9);
    v = '0; v[72] = 1'b1;
    directed("x72", v, 41'h4_8000_0000);
    directed("lowdeg", IN_W'(41'h1_2345_6789), 41'h1_2345_6789);
    directed("zero", '0, '0);

    // Stalled output with a second request waiting
    a_vec = rand_wide();
    b_vec = rand_wide();
    exp_a = ref_mod(a_vec);
    accept("b2b_a", a_vec);
    wait_result(lat);
    check("b2b_a_lat", IN_W'(lat), IN_W'(NUM_ITER));
    in_valid  = 1'b1;
    in_data   = b_vec;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", IN_W'(out_valid), IN_W'(1));
      check("stall_data", IN_W'(out_data), IN_W'(exp_a));
      check("stall_in_ready", IN_W'(in_ready), IN_W'(0));
      tick;
    end
    out_ready = 1'b1;
    check("hs_data", IN_W'(out_data), IN_W'(exp_a));
    tick;
    out_ready = 1'b0;
    check("hs_out_valid", IN_W'(out_valid), IN_W'(0));
    check("hs_busy", IN_W'(busy), IN_W'(0));
    check("hs_in_ready", IN_W'(in_ready), IN_W'(1));
    tick;
    in_valid = 1'b0;
    check("b2b_b_accepted", IN_W'(busy), IN_W'(1));
    wait_result(lat);
    check("b2b_b_lat", IN_W'(lat), IN_W'(NUM_ITER));
    check("b2b_b_data", IN_W'(out_data), IN_W'(ref_mod(b_vec)));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Reset in the middle of REDUCE
    v = '0; v[60] = 1'b1; v[45] = 1'b1;
    accept("midrst", v);
    tick; tick; tick;
    rst = 1'b0;
    #1;
    check("midrst_busy", IN_W'(busy), IN_W'(0));
    check("midrst_in_ready", IN_W'(in_ready), IN_W'(0));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      tick;
    end
    check("midrst_no_valid", IN_W'(n), IN_W'(0));
    rst = 1'b1;
    #1;
    v = '0; v[41] = 1'b1;
    directed("post_rst", v, 41'h9);

    // Random products through all three digit widths
    rst = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    for (int t = 0; t < 1000; t++) begin
      ra  = $urandom;
      r64 = {$urandom, $urandom};
      rb  = r64[M-1:0];
      v   = clmul(ra, rb);
      in_valid = 1'b1;
      in_data  = v;
      tick;
      in_valid = 1'b0;
      n = 0;
      while (!(out_valid && out_valid_d1 && out_valid_d32) && n < 100) begin
        tick;
        n++;
      end
      check("rnd_d4", IN_W'(out_data), IN_W'(ref_mod(v)));
      check("rnd_d1", IN_W'(out_data_d1), IN_W'(ref_mod(v)));
      check("rnd_d32", IN_W'(out_data_d32), IN_W'(ref_mod(v)));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
